// File: rtl/sha3_pkg.sv
// Shared constants and FSM encoding for the SHA-3-256 message sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package sha3_pkg;

  localparam int RATE_BYTES      = 136;
  localparam int WORDS_PER_BLOCK = RATE_BYTES / 8;
  localparam int BLOCK_W         = 8 * RATE_BYTES;
  localparam int DIGEST_W        = 256;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_PAD   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_e;

endpackage

// File: rtl/sha3_pad_insert.sv
// Applies SHA-3 padding to a rate block: ORs the domain byte at offset len and the final bit at byte 135.
// Latency: combinational.
// Backpressure: none.
// Ports: block_i (unpadded block, byte 0 at the MSBs), len_i (message bytes in block, < RATE_BYTES),
//        block_o (padded block).
module sha3_pad_insert
  import sha3_pkg::*;
(
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [7:0]         len_i,
  output logic [BLOCK_W-1:0] block_o
);

  // Domain and final bytes are ORed independently so that len=135 merges into 0x86.
  always_comb begin
    block_o = block_i;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (len_i == 8'(i)) begin
        block_o[BLOCK_W-1-8*i -: 8] = block_o[BLOCK_W-1-8*i -: 8] | PAD_DOMAIN;
      end
    end
    block_o[7:0] = block_o[7:0] | PAD_FINAL;
  end

endmodule

// File: rtl/sha3_msg_sequencer.sv
// Packs a 64-bit word stream into padded SHA-3-256 rate blocks, drives sha3_core, returns the digest.
// Latency: one ISSUE cycle after a block completes (plus PAD cycle for the final block), then core time.
// Backpressure: in_ready only in FILL; core_ready gates core_start; digest held until digest_ready.
// Ports: in_* word stream (byte 0 at [63:56]); core_* handshake to sha3_core; digest/digest_valid/digest_ready out.
module sha3_msg_sequencer
  import sha3_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [63:0]         in_data,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [3:0]          in_nbytes,
  output logic                in_ready,
  output logic [BLOCK_W-1:0]  core_block,
  output logic                core_start,
  output logic                core_is_last,
  input  logic                core_ready,
  input  logic [DIGEST_W-1:0] core_hash,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready
);

  localparam logic [BLOCK_W-1:0] PAD_ONLY_BLOCK = {PAD_DOMAIN, {(BLOCK_W-16){1'b0}}, PAD_FINAL};

  seq_state_e          state_q, state_d;
  logic [4:0]          word_idx_q, word_idx_d;
  logic [BLOCK_W-1:0]  buf_q, buf_d, padded;
  logic [7:0]          len_q, len_d;
  logic                is_last_q, is_last_d;
  logic                pad_pending_q, pad_pending_d;
  logic                busy_first_q, busy_first_d;
  logic                in_ready_q, in_ready_d;
  logic                digest_valid_q, digest_valid_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;

  logic [3:0]          nbytes_clamped;
  logic [63:0]         word_mask;
  logic [7:0]          len_now;
  logic [10:0]         word_msb;

  // Only the leading n bytes of a last word are kept; the tail is forced to zero.
  assign nbytes_clamped = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
  assign word_mask      = in_last ? ~({64{1'b1}} >> {nbytes_clamped, 3'b000}) : {64{1'b1}};
  assign len_now        = {word_idx_q, 3'b000} + {4'b0000, nbytes_clamped};
  assign word_msb       = 11'(BLOCK_W - 1) - {word_idx_q, 6'b000000};

  sha3_pad_insert u_pad (
    .block_i (buf_q),
    .len_i   (len_q),
    .block_o (padded)
  );

  always_comb begin
    state_d        = state_q;
    word_idx_d     = word_idx_q;
    buf_d          = buf_q;
    len_d          = len_q;
    is_last_d      = is_last_q;
    pad_pending_d  = pad_pending_q;
    busy_first_d   = busy_first_q;
    digest_d       = digest_q;
    digest_valid_d = digest_valid_q;

    unique case (state_q)
      ST_FILL: begin
        if (in_valid && in_ready_q) begin
          buf_d[word_msb -: 64] = in_data & word_mask;
          word_idx_d = word_idx_q + 5'd1;
          if (in_last) begin
            if (len_now == 8'(RATE_BYTES)) begin
              // Message ends exactly on a block boundary: padding needs a block of its own.
              is_last_d     = 1'b0;
              pad_pending_d = 1'b1;
              state_d       = ST_ISSUE;
            end else begin
              len_d   = len_now;
              state_d = ST_PAD;
            end
          end else if (word_idx_q == 5'(WORDS_PER_BLOCK - 1)) begin
            is_last_d     = 1'b0;
            pad_pending_d = 1'b0;
            state_d       = ST_ISSUE;
          end
        end
      end
      ST_PAD: begin
        buf_d     = padded;
        is_last_d = 1'b1;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (core_ready) begin
          busy_first_d = 1'b1;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The core deasserts ready on the accepting edge, so the first BUSY cycle's ready is stale.
        if (busy_first_q) begin
          busy_first_d = 1'b0;
        end else if (core_ready) begin
          if (is_last_q) begin
            digest_d       = core_hash;
            digest_valid_d = 1'b1;
            state_d        = ST_DRAIN;
          end else if (pad_pending_q) begin
            buf_d         = PAD_ONLY_BLOCK;
            pad_pending_d = 1'b0;
            is_last_d     = 1'b1;
            state_d       = ST_ISSUE;
          end else begin
            buf_d      = '0;
            word_idx_d = '0;
            state_d    = ST_FILL;
          end
        end
      end
      ST_DRAIN: begin
        if (digest_ready) begin
          digest_valid_d = 1'b0;
          buf_d          = '0;
          word_idx_d     = '0;
          is_last_d      = 1'b0;
          state_d        = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    // Registered so in_ready stays low throughout reset and rises one cycle after release.
    in_ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      word_idx_q     <= '0;
      buf_q          <= '0;
      len_q          <= '0;
      is_last_q      <= 1'b0;
      pad_pending_q  <= 1'b0;
      busy_first_q   <= 1'b0;
      in_ready_q     <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_idx_q     <= word_idx_d;
      buf_q          <= buf_d;
      len_q          <= len_d;
      is_last_q      <= is_last_d;
      pad_pending_q  <= pad_pending_d;
      busy_first_q   <= busy_first_d;
      in_ready_q     <= in_ready_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign core_block   = buf_q;
  assign core_start   = (state_q == ST_ISSUE) && core_ready;
  assign core_is_last = is_last_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha3_msg_sequencer.sv
module tb_sha3_msg_sequencer;
  import sha3_pkg::*;

  localparam logic [255:0] H_EMPTY = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
  localparam logic [255:0] H_ABC   = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [63:0]         in_data;
  logic                in_valid;
  logic                in_last;
  logic [3:0]          in_nbytes;
  logic                in_ready;
  logic [BLOCK_W-1:0]  core_block;
  logic                core_start;
  logic                core_is_last;
  logic                core_ready = 1'b1;
  logic [DIGEST_W-1:0] core_hash  = '0;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                digest_ready;

  sha3_msg_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_nbytes    (in_nbytes),
    .in_ready     (in_ready),
    .core_block   (core_block),
    .core_start   (core_start),
    .core_is_last (core_is_last),
    .core_ready   (core_ready),
    .core_hash    (core_hash),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_block(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    logic [1279:0] g, e;
    g = {192'b0, got};
    e = {192'b0, exp};
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("%s[%0d]", tag, k), g[256*k +: 256], e[256*k +: 256]);
  endtask

  // Mock core: logs each start, drops ready for core_lat cycles, then returns core_hash_next.
  logic [BLOCK_W-1:0] blk_log[$];
  logic               last_log[$];
  int                 core_lat = 5;
  logic [255:0]       core_hash_next = '0;

  always @(posedge clk) begin
    if (core_start === 1'b1) begin
      blk_log.push_back(core_block);
      last_log.push_back(core_is_last);
      #1 core_ready = 1'b0;
      repeat (core_lat) @(posedge clk);
      #1 core_hash = core_hash_next;
      core_ready = 1'b1;
    end
  end

  function automatic logic [7:0] msg_byte(input int i);
    return 8'(i + 1);
  endfunction

  // Expected block: n message bytes starting at message offset 'start', optionally padded.
  function automatic logic [BLOCK_W-1:0] exp_block(input int start, input int n, input bit pad);
    logic [BLOCK_W-1:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[BLOCK_W-1-8*i -: 8] = msg_byte(start + i);
    if (pad) begin
      b[BLOCK_W-1-8*n -: 8] = b[BLOCK_W-1-8*n -: 8] | 8'h06;
      b[7:0] = b[7:0] | 8'h80;
    end
    return b;
  endfunction

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb, output int waits);
    logic ok;
    ok = 1'b0;
    in_data = d; in_last = last; in_nbytes = nb; in_valid = 1'b1;
    for (waits = 0; waits < 1000; waits++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    check_eq("word_accepted", 256'(ok), 256'(1));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  int resume_waits;
  int starts_at_resume;

  task automatic send_msg(input int len, input bit gaps);
    int nw, nb, waits;
    logic [63:0] d;
    nw = (len == 0) ? 1 : (len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? len - 8 * w : 8;
      for (int b = 0; b < 8; b++) d[63-8*b -: 8] = (b < nb) ? msg_byte(8 * w + b) : 8'hEE;
      send_word(d, (w == nw - 1), 4'(nb), waits);
      if (w == 17) begin
        resume_waits     = waits;
        starts_at_resume = blk_log.size();
      end
      if (gaps && w != 16) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_abc();
    int waits;
    send_word(64'h6162630000000000, 1'b1, 4'd3, waits);
  endtask

  // Returns at a negedge with digest_valid sampled high (or after the bound).
  task automatic wait_dv(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (digest_valid) break;
    end
    check_eq({tag, "_dv"}, 256'(digest_valid), 256'(1));
  endtask

  task automatic consume(input string tag);
    digest_ready = 1'b1;
    @(posedge clk); #1;
    digest_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_dv_clr"}, 256'(digest_valid), 256'(0));
    check_eq({tag, "_rdy_back"}, 256'(in_ready), 256'(1));
    @(posedge clk); #1;
  endtask

  task automatic run_digest(input string tag, input logic [255:0] exp);
    wait_dv(tag);
    check_eq({tag, "_digest"}, digest, exp);
    consume(tag);
  endtask

  task automatic clear_log();
    blk_log.delete();
    last_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [255:0] d0;
    int lost, changed, rdy_hi, starts_before;
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nbytes = '0; digest_ready = 1'b0;

    // Reset state
    #1;
    check_eq("rst_in_ready", 256'(in_ready), 256'(0));
    check_eq("rst_core_start", 256'(core_start), 256'(0));
    check_eq("rst_core_is_last", 256'(core_is_last), 256'(0));
    check_eq("rst_digest_valid", 256'(digest_valid), 256'(0));
    check_eq("rst_digest", digest, 256'(0));
    chk_block("rst_block", core_block, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready_pre", 256'(in_ready), 256'(0));
    @(negedge clk);
    check_eq("in_ready_up", 256'(in_ready), 256'(1));
    @(posedge clk); #1;

    // Empty message
    clear_log(); core_hash_next = H_EMPTY;
    send_msg(0, 1'b0);
    run_digest("empty", H_EMPTY);
    check_eq("empty_starts", 256'(blk_log.size()), 256'(1));
    if (blk_log.size() >= 1) begin
      check_eq("empty_last", 256'(last_log[0]), 256'(1));
      chk_block("empty_blk", blk_log[0], {8'h06, 1072'h0, 8'h80});
    end

    // "abc"
    clear_log(); core_hash_next = H_ABC;
    send_abc();
    run_digest("abc", H_ABC);
    check_eq("abc_starts", 256'(blk_log.size()), 256'(1));
    if (blk_log.size() >= 1) begin
      check_eq("abc_last", 256'(last_log[0]), 256'(1));
      chk_block("abc_blk", blk_log[0], {24'h616263, 8'h06, 1048'h0, 8'h80});
    end

    // 135 bytes: domain and final byte share byte 135 (0x86); garbage tail byte must be dropped
    clear_log(); core_hash_next = 256'h135;
    send_msg(135, 1'b0);
    run_digest("m135", 256'h135);
    check_eq("m135_starts", 256'(blk_log.size()), 256'(1));
    if (blk_log.size() >= 1) begin
      check_eq("m135_last", 256'(last_log[0]), 256'(1));
      check_eq("m135_byte135", 256'(blk_log[0][7:0]), 256'(8'h86));
      chk_block("m135_blk", blk_log[0], exp_block(0, 135, 1'b1));
    end

    // 136 bytes: data block, then pad-only block
    clear_log(); core_hash_next = 256'h136;
    send_msg(136, 1'b0);
    run_digest("m136", 256'h136);
    check_eq("m136_starts", 256'(blk_log.size()), 256'(2));
    if (blk_log.size() >= 2) begin
      check_eq("m136_last0", 256'(last_log[0]), 256'(0));
      check_eq("m136_last1", 256'(last_log[1]), 256'(1));
      chk_block("m136_blk0", blk_log[0], exp_block(0, 136, 1'b0));
      chk_block("m136_blk1", blk_log[1], {8'h06, 1072'h0, 8'h80});
    end

    // 200 bytes with input gaps
    clear_log(); core_hash_next = 256'h200; resume_waits = 0; starts_at_resume = 0;
    send_msg(200, 1'b1);
    run_digest("m200", 256'h200);
    check_eq("m200_starts", 256'(blk_log.size()), 256'(2));
    check_eq("m200_start_before_resume", 256'(starts_at_resume), 256'(1));
    check_eq("m200_rdy_low_long", 256'(resume_waits >= core_lat), 256'(1));
    if (blk_log.size() >= 2) begin
      check_eq("m200_last0", 256'(last_log[0]), 256'(0));
      check_eq("m200_last1", 256'(last_log[1]), 256'(1));
      chk_block("m200_blk0", blk_log[0], exp_block(0, 136, 1'b0));
      chk_block("m200_blk1", blk_log[1], exp_block(136, 64, 1'b1));
    end

    // Back-to-back "abc" with digest held 20 cycles
    clear_log(); core_hash_next = H_ABC;
    send_abc();
    wait_dv("hold");
    d0 = digest; lost = 0; changed = 0; rdy_hi = 0; starts_before = blk_log.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!digest_valid) lost++;
      if (digest !== d0) changed++;
      if (in_ready) rdy_hi++;
    end
    check_eq("hold_digest", d0, H_ABC);
    check_eq("hold_dv_drops", 256'(lost), 256'(0));
    check_eq("hold_digest_changes", 256'(changed), 256'(0));
    check_eq("hold_in_ready_high", 256'(rdy_hi), 256'(0));
    check_eq("hold_no_new_start", 256'(blk_log.size()), 256'(starts_before));
    consume("hold");
    send_abc();
    run_digest("abc2", H_ABC);
    check_eq("abc2_starts", 256'(blk_log.size()), 256'(2));

    // Reset while the core is busy
    clear_log(); core_lat = 10; core_hash_next = H_ABC;
    send_abc();
    for (int i = 0; i < 1000 && blk_log.size() == 0; i++) @(posedge clk);
    #2;
    check_eq("midrst_started", 256'(blk_log.size()), 256'(1));
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 256'(in_ready), 256'(0));
    check_eq("midrst_core_start", 256'(core_start), 256'(0));
    check_eq("midrst_core_is_last", 256'(core_is_last), 256'(0));
    check_eq("midrst_digest_valid", 256'(digest_valid), 256'(0));
    check_eq("midrst_digest", digest, 256'(0));
    chk_block("midrst_block", core_block, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log(); core_lat = 5;
    send_abc();
    run_digest("postrst", H_ABC);
    check_eq("postrst_starts", 256'(blk_log.size()), 256'(1));
    if (blk_log.size() >= 1)
      chk_block("postrst_blk", blk_log[0], {24'h616263, 8'h06, 1048'h0, 8'h80});

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sha3_msg_sequencer.md
Name: sha3_msg_sequencer

Overview:
- Streams an arbitrary-length byte message into sha3_core, one 1088-bit rate block at a time.
- Packs 64-bit input words into a block buffer and applies SHA-3 domain/padding bytes (0x06 … 0x80).
- Issues start/is_last to the core, honouring its ready handshake, then presents the 256-bit digest on a valid/ready output.
- Sits between a bus-side producer (DMA/CSR FIFO) and sha3_core.

Parameters:
- RATE_BYTES, 136, rate in bytes; fixed for SHA-3-256. Block width is 8*RATE_BYTES = 1088.
- WORDS_PER_BLOCK, 17, RATE_BYTES/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  64  message word; byte 0 (first in message order) at [63:56]
- in_valid  in  1  in_data valid
- in_last  in  1  final word of message
- in_nbytes  in  4  valid bytes in the last word (0..8); ignored when in_last=0
- in_ready  out  1  word accepted when in_valid & in_ready
- core_block  out  1088  to sha3_core.message_block; message byte i of the block at [1087-8i -: 8]
- core_start  out  1  one-cycle start pulse to the core
- core_is_last  out  1  qualifies core_start: final block of the message
- core_ready  in  1  sha3_core.ready
- core_hash  in  256  sha3_core.hash_out
- digest  out  256  registered copy of core_hash
- digest_valid  out  1  digest available
- digest_ready  in  1  consumer accepts digest

Behaviour:
- Reset values: all outputs 0; in_ready=0; FSM=FILL; word_idx=0; block buffer=0. in_ready rises the first cycle after reset release.
- States: FILL, PAD, ISSUE, BUSY, DRAIN.
- FILL:
  - in_ready=1. On each accepted word, write it to buffer word word_idx and increment word_idx.
  - Non-last word accepted at word_idx=16: go to ISSUE with is_last=0 and clear pad_pending.
  - in_last word: compute byte offset L = 8*word_idx + n, where n = in_nbytes (values 9..15 clamp to 8). Write only the n valid bytes; remaining bytes stay 0.
  - If L = 136 (block exactly full): go to ISSUE with is_last=0 and set pad_pending=1.
  - If L < 136: go to PAD.
- PAD (1 cycle):
  - byte[L] |= 0x06; byte[135] |= 0x80. For L=135 the result is 0x86.
  - Go to ISSUE with is_last=1.
- ISSUE:
  - Wait for core_ready=1, then assert core_start=1 for exactly one cycle with core_is_last.
  - core_block is held stable from ISSUE entry until BUSY exits.
  - Go to BUSY.
- BUSY:
  - core_ready is ignored on the first cycle after the start pulse, because the core drops ready on the accepting edge. After that, wait for core_ready=1.
  - Then, if is_last=1: capture core_hash into digest, set digest_valid=1, go to DRAIN.
  - Else if pad_pending=1: clear the buffer, write the pad-only block (byte0=0x06, byte135=0x80), clear pad_pending, go to ISSUE with is_last=1.
  - Else: clear the buffer, word_idx=0, go to FILL.
- DRAIN:
  - digest_valid stays high and digest stays stable until digest_ready=1.
  - On that cycle: digest_valid→0, buffer cleared, word_idx=0, go to FILL.
- Empty message: a single in_last word with in_nbytes=0 at word_idx=0 gives L=0 and one padded block.
- Input stalls: in_valid low for any number of cycles in FILL leaves the FSM and buffer unchanged.
- in_ready=0 in every state except FILL. No new message is accepted until the digest is consumed.
- Reset mid-operation: everything returns to reset values immediately. Any core operation in flight is abandoned; the next ISSUE still waits for core_ready.
- Never more than one start per core_ready low/high cycle.

Decomposition:
- Package sha3_pkg:
  - RATE_BYTES=136, DIGEST_W=256, PAD_DOMAIN=8'h06, PAD_FINAL=8'h80.
  - FSM state enum.
- One natural sub-module: sha3_pad_insert, combinational. Inputs are buffer and L; output is the padded buffer with the 0x06 OR at byte L and 0x80 OR at byte 135.
- The FSM and word packing stay in the top module.

Test Plan:
- Empty message (one last word, nbytes=0) → one start with is_last=1; block = {06, 1072'h0, 80}; digest = a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
- "abc" (last word 0x6162630000000000, nbytes=3) → block = {616263, 06, 1048'h0, 80}; digest = 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- 135-byte message (16 full words + last nbytes=7) → one start with is_last=1; block byte135 = 0x86 and no other pad bytes.
- 136-byte message (17 full words, last nbytes=8) → two starts:
  - first is_last=0 carrying the data block;
  - second is_last=1 with block {06, 1072'h0, 80}.
- 200-byte message with in_valid gaps → first block has is_last=0 and contains bytes 0..135. Second block has bytes 136..199, 0x06 at byte 64, and 0x80 at byte 135. in_ready stays low from the block-completing word until the first block's BUSY exit.
- Back-to-back "abc" with digest_ready held low 20 cycles → digest_valid is held and digest stays stable; in_ready=0 throughout. After acceptance, the second message gives the same digest.
- Assert rst_n=0 during BUSY → all outputs return to 0 immediately. The next message's digest is still correct.
